perceptron_trainer: RTL
=======================

Name: perceptron_trainer

Overview:
- Controller and learning-rule engine on the opposite end of the perceptron's enable/fire handshake.
- Holds the weight vector and presents a training sample.
- Launches a forward pass with a one-cycle enable pulse, then waits for fire and captures y.
- Applies the perceptron rule w_i += (target - y) * x_i * 2^-RATE_SHIFT serially, one lane per cycle; all values are signed Q8.8.

Parameters:
N, 8, number of inputs/weights (must match perceptron N)
RATE_SHIFT, 4, learning rate = 2^-RATE_SHIFT
TIMEOUT, 64, max cycles in WAIT before abort (fire normally arrives N+4 cycles after enable)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin one training step (sampled in IDLE only)
load_w  input  1  load w_init into weight registers (IDLE only)
w_init  input  16*N  initial weights, lane i at [16i+15:16i]
x_in  input  16*N  training sample, captured on accepted start
target  input  16  desired output, captured on accepted start
enable  output  1  one-cycle launch pulse to perceptron
x  output  16*N  registered sample driven to perceptron
w  output  16*N  current weight registers driven to perceptron
y  input  16  perceptron output, valid while fire=1
fire  input  1  perceptron result-valid pulse
err  output  16  last saturated error (target - y)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse: update complete
timeout  output  1  sticky abort flag, cleared on next accepted start

Behaviour:
- Reset (async, immediate): state=IDLE; enable, busy, done, timeout=0; x, w, err, internal index and target registers=0.
- IDLE:
  - load_w=1: w<=w_init, no state change. load_w has priority over start in the same cycle; that start is dropped.
  - Else start=1: x<=x_in, target captured, timeout<=0, go LAUNCH.
- LAUNCH (1 cycle): enable=1, go WAIT. Cycle counter cleared.
- WAIT:
  - fire=1: capture y, go ERROR.
  - Else counter increments. When counter reaches TIMEOUT-1 without fire: timeout<=1, go IDLE. Weights unchanged, no done pulse.
- ERROR (1 cycle): err <= sat16(target - y_captured).
  - Difference computed at 17 bits signed.
  - Saturate to 0x7FFF / 0x8000.
  - Lane index i cleared; go UPDATE.
- UPDATE (exactly N cycles, i = 0..N-1):
  - prod = err * x_i, 32-bit signed.
  - delta = prod >>> (8 + RATE_SHIFT), arithmetic shift, truncation toward -inf.
  - w_i <= sat16(w_i + delta), sum computed at 17+ bits.
  - One lane written per cycle; other lanes hold.
  - After lane N-1, go DONE.
- DONE (1 cycle): done=1, go IDLE.
- Latency: fire sampled at edge F → done high in cycle F+N+2 (ERROR, N UPDATE cycles, DONE).
- Zero error still runs all N UPDATE cycles, so latency is data-independent.
- Inputs ignored outside their states:
  - start and load_w while busy.
  - fire outside WAIT.
  - x_in and target changes after capture.
- w and x are stable from LAUNCH through WAIT, so the perceptron sees constant operands for the whole forward pass.
- Reset mid-UPDATE: weights return to 0 (not partially updated values). The host must reload via load_w.
- Single multiplier shared across lanes; lane select is a mux on i.

Test Plan:
1. Reset while in UPDATE (assert rst at lane 3) → outputs immediately 0, state IDLE, w=0, busy=0, no done.
2. Basic learning step:
   - Stimulus: load_w with all 0x0000; start with x_in all 0x0100, target=0x0100; model returns y=0x0000 with fire at enable+12 cycles.
   - Response: err=0x0100, every w_i=0x0010.
   - Timing: done pulses exactly N+2=10 cycles after fire; enable high exactly one cycle.
3. Zero error: target=y=0x0100 → err=0; w unchanged; done still at fire+10.
4. Saturation:
   - Error: target=0x7FFF, y=0x8000 → err=0x7FFF.
   - Weights: with w_i=0x7FF0 and x_i=0x7FFF, w_i=0x7FFF.
   - Negative mirror: target=0x8000, y=0x7FFF, w_i=0x8010, x_i=0x7FFF → err=0x8000, w_i=0x8000.
5. Timeout: start, never assert fire → timeout=1 at TIMEOUT cycles after entering WAIT; busy drops; w unchanged; next start clears timeout.
6. Priority and ignoring:
   - load_w and start in the same IDLE cycle → weights loaded, no enable pulse.
   - start, load_w, and spurious fire pulses during UPDATE → no effect on sequence or weights.

Source files
------------

// File: rtl/perceptron_trainer.sv
//==============================================================================
// perceptron_trainer : controller and serial learning-rule engine for a
//                      perceptron over an enable/fire handshake (Q8.8)
// Revision 1.0
//==============================================================================
`default_nettype none

module perceptron_trainer #(
  parameter int N          = 8,
  parameter int RATE_SHIFT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_w,
  input  logic [16*N-1:0]   w_init,
  input  logic [16*N-1:0]   x_in,
  input  logic [15:0]       target,
  output logic              enable,
  output logic [16*N-1:0]   x,
  output logic [16*N-1:0]   w,
  input  logic [15:0]       y,
  input  logic              fire,
  output logic [15:0]       err,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ERROR  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]          state;
  logic [16*N-1:0]     x_r;
  logic [16*N-1:0]     w_r;
  logic signed [15:0]  err_r;
  logic [15:0]         tgt_r;
  logic [15:0]         y_cap;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic                timeout_r;

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'h7FFF;
    else if (v < -32'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  logic signed [16:0] diff;
  logic signed [15:0] x_lane;
  logic signed [15:0] w_lane;
  logic signed [31:0] prod;
  logic signed [31:0] delta;
  logic signed [31:0] wsum;
  logic [15:0]        w_upd;

  // One shared multiplier; the active lane is muxed in by idx.
  assign diff   = {tgt_r[15], tgt_r} - {y_cap[15], y_cap};
  assign x_lane = x_r[idx*16 +: 16];
  assign w_lane = w_r[idx*16 +: 16];
  assign prod   = err_r * x_lane;
  assign delta  = prod >>> (8 + RATE_SHIFT);
  assign wsum   = {{16{w_lane[15]}}, w_lane} + delta;
  assign w_upd  = sat16(wsum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x_r       <= '0;
      w_r       <= '0;
      err_r     <= '0;
      tgt_r     <= '0;
      y_cap     <= '0;
      idx       <= '0;
      cnt       <= '0;
      timeout_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_w) begin
            w_r <= w_init;
          end else if (start) begin
            x_r       <= x_in;
            tgt_r     <= target;
            timeout_r <= 1'b0;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fire) begin
            y_cap <= y;
            state <= S_ERROR;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_r <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ERROR: begin
          err_r <= sat16({{15{diff[16]}}, diff});
          idx   <= '0;
          state <= S_UPDATE;
        end
        S_UPDATE: begin
          w_r[idx*16 +: 16] <= w_upd;
          if (idx == IW'(N - 1))
            state <= S_DONE;
          else
            idx <= idx + 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign enable  = (state == S_LAUNCH);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign x       = x_r;
  assign w       = w_r;
  assign err     = err_r;
  assign timeout = timeout_r;

endmodule

`default_nettype wire
